// File: rtl/sumsq_16_pkg.sv
// Shared constants for the sum-of-squares feeder: default widths,
// iteration count and FSM state encoding.
package sumsq_16_pkg;

    localparam int W_IN_DEF  = 8;
    localparam int W_OUT_DEF = 2 * W_IN_DEF;
    localparam int ITER_DEF  = W_IN_DEF + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MULX  = 3'd1;
    localparam logic [2:0] S_MULY  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

endpackage

// File: rtl/sumsq_16_shift_add_mul.sv
// Shift-add squaring datapath. One accumulator is shared by both squares:
// the FSM loads an operand magnitude into multiplicand and multiplier,
// steps W_IN+1 times, then reloads the next operand without clearing acc.
module shift_add_mul
    import sumsq_16_pkg::*;
#(
    parameter int W_IN = W_IN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr_acc,
    input  logic              step,
    input  logic [W_IN:0]     op,
    output logic [2*W_IN-1:0] rr_next,
    output logic              last
);

    localparam int ITER  = W_IN + 1;
    localparam int W_ACC = 2 * W_IN + 1;
    localparam int CW    = $clog2(ITER);

    logic [W_ACC-1:0] acc_q, acc_d, acc_step, addend;
    logic [W_ACC-1:0] mcand_q, mcand_d;
    logic [W_IN:0]    mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Next-state of the iteration registers; load wins over the shift so a
    // step and a reload can share the same edge.
    always_comb begin
        addend   = mplier_q[0] ? mcand_q : '0;
        acc_step = acc_q + addend;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (step) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
        if (load) begin
            mcand_d  = W_ACC'(op);
            mplier_d = op;
            cnt_d    = '0;
        end
        if (clr_acc) begin
            acc_d = '0;
        end
    end

    // Sum of squares never exceeds 2*(2^(W_IN-1))^2, so the top acc bit
    // is only headroom and the low W_OUT bits are the result.
    assign rr_next = acc_step[2*W_IN-1:0];
    assign last    = (cnt_q == CW'(ITER - 1));

    // Iteration registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/sumsq_16.sv
// Vector-magnitude feeder: computes X*X + Y*Y, presents it to the
// square-root stage with a one-cycle start pulse, and optionally waits for
// that stage's done edge before accepting new work.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | waiting for init; operands captured on accept
//   S_MULX  | W_IN+1 shift-add steps squaring |X|
//   S_MULY  | W_IN+1 steps squaring |Y| onto the same acc
//   S_ISSUE | out_RR valid, out_INIT/out_DONE pulsed
//   S_WAIT  | held until rising edge of in_DONE_R
module sumsq_16
    import sumsq_16_pkg::*;
#(
    parameter int W_IN      = W_IN_DEF,
    parameter bit WAIT_DONE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic [W_IN-1:0]   in_X,
    input  logic [W_IN-1:0]   in_Y,
    input  logic              in_DONE_R,
    output logic [2*W_IN-1:0] out_RR,
    output logic              out_INIT,
    output logic              out_BUSY,
    output logic              out_DONE
);

    localparam int W_OUT = 2 * W_IN;

    logic [2:0]       state_q, state_d;
    logic [W_IN:0]    mag_y_q, mag_y_d;
    logic [W_OUT-1:0] rr_q, rr_d;
    logic             init_q, init_d;
    logic             busy_q, busy_d;
    logic             done_prev_q, done_prev_d;

    logic [W_IN:0]    ext_x, ext_y, mag_x, mag_y;
    logic             mul_load, mul_clr, mul_step, mul_last;
    logic [W_IN:0]    mul_op;
    logic [W_OUT-1:0] rr_next;

    // Magnitudes need one extra bit so the most negative input maps to
    // +2^(W_IN-1) instead of wrapping.
    always_comb begin
        ext_x = {in_X[W_IN-1], in_X};
        ext_y = {in_Y[W_IN-1], in_Y};
        mag_x = ext_x[W_IN] ? (~ext_x + 1'b1) : ext_x;
        mag_y = ext_y[W_IN] ? (~ext_y + 1'b1) : ext_y;
    end

    // Sequencing FSM and datapath controls.
    always_comb begin
        state_d     = state_q;
        mag_y_d     = mag_y_q;
        rr_d        = rr_q;
        init_d      = 1'b0;
        done_prev_d = done_prev_q;
        mul_load    = 1'b0;
        mul_clr     = 1'b0;
        mul_step    = 1'b0;
        mul_op      = (state_q == S_IDLE) ? mag_x : mag_y_q;
        case (state_q)
            S_IDLE: begin
                if (init) begin
                    mul_load = 1'b1;
                    mul_clr  = 1'b1;
                    mag_y_d  = mag_y;
                    state_d  = S_MULX;
                end
            end
            S_MULX: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    mul_load = 1'b1;
                    state_d  = S_MULY;
                end
            end
            S_MULY: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    rr_d    = rr_next;
                    init_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Seed the edge detector so a level left high from the
                // previous operation cannot release WAIT.
                done_prev_d = in_DONE_R;
                state_d     = WAIT_DONE ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                done_prev_d = in_DONE_R;
                if (in_DONE_R && !done_prev_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    shift_add_mul #(
        .W_IN (W_IN)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load),
        .clr_acc (mul_clr),
        .step    (mul_step),
        .op      (mul_op),
        .rr_next (rr_next),
        .last    (mul_last)
    );

    // State, operand, edge-detect and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mag_y_q     <= '0;
            rr_q        <= '0;
            init_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_y_q     <= mag_y_d;
            rr_q        <= rr_d;
            init_q      <= init_d;
            busy_q      <= busy_d;
            done_prev_q <= done_prev_d;
        end
    end

    assign out_RR   = rr_q;
    assign out_INIT = init_q;
    assign out_DONE = init_q;
    assign out_BUSY = busy_q;

endmodule

// File: tb/tb_sumsq_16.sv
// Bench for sumsq_16: two instances (WAIT_DONE=1 and WAIT_DONE=0) share
// stimulus; a cycle-count transaction model predicts every output each
// cycle, and directed checks pin key values at known cycles.
module tb_sumsq_16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              init = 1'b0;
    logic signed [7:0] x_in = '0;
    logic signed [7:0] y_in = '0;
    logic              done_r = 1'b0;

    logic [15:0] rr1, rr0;
    logic        ini1, ini0, bsy1, bsy0, dn1, dn0;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sumsq_16 #(.W_IN(8), .WAIT_DONE(1'b1)) dut (
        .clk(clk), .rst(rst), .init(init), .in_X(x_in), .in_Y(y_in),
        .in_DONE_R(done_r), .out_RR(rr1), .out_INIT(ini1),
        .out_BUSY(bsy1), .out_DONE(dn1)
    );

    sumsq_16 #(.W_IN(8), .WAIT_DONE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .init(init), .in_X(x_in), .in_Y(y_in),
        .in_DONE_R(done_r), .out_RR(rr0), .out_INIT(ini0),
        .out_BUSY(bsy0), .out_DONE(dn0)
    );

    // Transaction model: t counts cycles since accept; result appears at
    // t=19, t=20 means parked waiting for a done rising edge.
    typedef struct {
        bit busy;
        int t;
        int rr;
        int ex;
        bit prev;
    } mdl_t;

    mdl_t m1, m0;

    function automatic mdl_t mstep(mdl_t m, bit wd, bit r, bit i,
                                   int x, int y, bit d);
        mdl_t n = m;
        if (!r) begin
            n.busy = 0; n.t = 0; n.rr = 0; n.ex = 0; n.prev = 0;
        end else if (!m.busy) begin
            if (i) begin
                n.busy = 1; n.t = 1; n.ex = x * x + y * y;
            end
        end else if (m.t < 19) begin
            n.t = m.t + 1;
            if (n.t == 19) n.rr = m.ex;
        end else if (m.t == 19) begin
            n.prev = d;
            if (wd) n.t = 20;
            else    n.busy = 0;
        end else begin
            n.prev = d;
            if (d && !m.prev) n.busy = 0;
        end
        return n;
    endfunction

    initial begin
        m1 = '{busy: 0, t: 0, rr: 0, ex: 0, prev: 0};
        m0 = m1;
    end

    always @(posedge clk) begin
        m1 = mstep(m1, 1'b1, rst, init, int'(x_in), int'(y_in), done_r);
        m0 = mstep(m0, 1'b0, rst, init, int'(x_in), int'(y_in), done_r);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m1_rr",   32'(rr1),  32'(m1.rr));
            chk("m1_busy", 32'(bsy1), 32'(m1.busy));
            chk("m1_init", 32'(ini1), 32'(m1.busy && m1.t == 19));
            chk("m1_done", 32'(dn1),  32'(m1.busy && m1.t == 19));
            chk("m0_rr",   32'(rr0),  32'(m0.rr));
            chk("m0_busy", 32'(bsy0), 32'(m0.busy));
            chk("m0_init", 32'(ini0), 32'(m0.busy && m0.t == 19));
            chk("m0_done", 32'(dn0),  32'(m0.busy && m0.t == 19));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Accept at edge 0; returns in cycle 1.
    task automatic start(input int x, input int y);
        x_in = 8'(x);
        y_in = 8'(y);
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    // Run from cycle 1 to cycle 19 checking the pulse lands only at 19.
    task automatic run_to_issue(input string nm, input int exp_rr);
        for (int c = 1; c < 19; c++) begin
            if (c == 1) chk({nm, "_busy_c1"}, 32'(bsy1), 32'd1);
            chk({nm, "_noinit"}, 32'(ini1), 32'd0);
            tick();
        end
        chk({nm, "_init_c19"}, 32'(ini1), 32'd1);
        chk({nm, "_done_c19"}, 32'(dn1),  32'd1);
        chk({nm, "_rr"},       32'(rr1),  32'(exp_rr));
        chk({nm, "_rr0"},      32'(rr0),  32'(exp_rr));
    endtask

    task automatic release_wait();
        done_r = 1'b0;
        tick();
        done_r = 1'b1;
        tick();
        chk("release_idle", 32'(bsy1), 32'd0);
        done_r = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_rr",   32'(rr1),  32'd0);
        chk("rst_busy", 32'(bsy1), 32'd0);
        chk("rst_init", 32'(ini1), 32'd0);
        rst = 1'b1;
        tick();

        // 3,4 -> 25 with init re-asserted at cycles 5 and 12
        x_in = 8'sd3; y_in = 8'sd4; init = 1'b1;
        tick();
        init = 1'b0;
        for (int c = 1; c < 19; c++) begin
            if (c == 1) chk("b34_busy_c1", 32'(bsy1), 32'd1);
            if (c == 5 || c == 12) begin
                init = 1'b1; x_in = 8'sd9; y_in = 8'sd9;
            end else begin
                init = 1'b0;
            end
            tick();
        end
        init = 1'b0;
        chk("b34_init_c19", 32'(ini1), 32'd1);
        chk("b34_rr",       32'(rr1),  32'd25);
        tick();
        chk("wd0_idle_c20", 32'(bsy0), 32'd0);
        chk("wd1_wait_c20", 32'(bsy1), 32'd1);
        chk("rr_hold_c20",  32'(rr1),  32'd25);
        tick();
        release_wait();

        start(-128, -128);
        run_to_issue("m128", 32768);
        tick();
        release_wait();

        start(127, -1);
        run_to_issue("p127", 16130);
        tick();
        release_wait();

        start(0, 0);
        run_to_issue("zero", 0);
        tick();
        release_wait();

        // Reset in MULY discards the operation
        start(5, 6);
        for (int c = 1; c < 14; c++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_busy", 32'(bsy1), 32'd0);
        chk("mid_rst_rr",   32'(rr1),  32'd0);
        for (int c = 15; c < 26; c++) begin
            chk("mid_rst_noinit", 32'(ini1 | ini0), 32'd0);
            tick();
        end
        start(10, -20);
        run_to_issue("after_rst", 500);
        tick();
        release_wait();

        // done held high through the operation must not release WAIT
        done_r = 1'b1;
        start(1, 1);
        run_to_issue("hold", 2);
        for (int c = 20; c < 30; c++) begin
            tick();
            chk("hold_wait_busy", 32'(bsy1), 32'd1);
        end
        chk("hold_wd0_idle", 32'(bsy0), 32'd0);
        release_wait();

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
